// File: rtl/instr_rom_fetch.sv
// ---------------------------------------------------------------------------
// instr_rom_fetch
//
// Synchronous instruction memory for the CPU fetch stage. It accepts
// byte-addressed fetch requests over a valid/ready handshake and returns one
// registered instruction word per accepted request, one cycle after the
// request is accepted. A word-wide load port lets software or a debugger
// program the contents at run time. A flush input discards a held response,
// for example on a branch redirect. Misaligned and out-of-range fetches
// report a fault and return NOP_WORD.
//
// Parameters:
//   DATA_W   instruction width in bits (a multiple of 8, power-of-two bytes)
//   DEPTH    number of stored words
//   ADDR_W   byte-address width
//   NOP_WORD word returned on a fault; also the power-up content of every word
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset (response register only)
//   req_valid  fetch request present
//   req_addr   fetch byte address
//   req_ready  request is accepted when req_ready && req_valid
//   rsp_valid  rsp_data / rsp_fault hold a result
//   rsp_ready  consumer takes the result this cycle
//   rsp_data   fetched instruction word (NOP_WORD when faulted)
//   rsp_fault  bit0 misaligned, bit1 index out of range
//   flush      discard any held response
//   ld_en      write ld_data into memory this cycle (has priority over fetch)
//   ld_addr    byte address of the word to load; alignment bits ignored
//   ld_data    word to store
// ---------------------------------------------------------------------------
module instr_rom_fetch #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 128,
  parameter int                ADDR_W   = 9,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  // Number of byte-offset bits inside one word, and the widths of the word
  // index taken from a byte address and of the physical memory index.
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Contents survive reset; every word starts out as the NOP instruction.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  state_t            state_p1;
  logic [DATA_W-1:0] data_p1;
  logic [1:0]        fault_p1;

  logic              accept_p0;
  logic [1:0]        fault_p0;
  logic [IDX_W-1:0]  req_idx_p0;
  logic [IDX_W-1:0]  ld_idx_p0;
  logic              ld_in_range_p0;
  logic              unused_ld_off;

  // A word index is out of range when it reaches DEPTH. The extra top bit
  // keeps the comparison correct when DEPTH equals 2**IDX_W.
  function automatic logic idx_out_of_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} >= (IDX_W + 1)'(DEPTH);
  endfunction

  // Fault code for a fetch byte address: bit0 misaligned, bit1 out of range.
  // The two bits are independent, so both can be set together.
  function automatic logic [1:0] fetch_fault(input logic [ADDR_W-1:0] addr);
    logic [1:0] f;
    f[0] = |addr[OFF_W-1:0];
    f[1] = idx_out_of_range(addr[ADDR_W-1:OFF_W]);
    return f;
  endfunction

  // ---- stage p0: request decode and handshake -----------------------------
  // A load blocks any fetch in the same cycle. A held response makes room for
  // a new one when it is consumed or flushed in the same cycle, which is what
  // allows one fetch per cycle under a continuously ready consumer.
  assign req_ready  = !ld_en && ((state_p1 == EMPTY) || rsp_ready || flush);
  assign accept_p0  = req_valid && req_ready;
  assign req_idx_p0 = req_addr[ADDR_W-1:OFF_W];
  assign fault_p0   = fetch_fault(req_addr);

  // Loads ignore the byte offset within the word, and loads beyond DEPTH are
  // dropped rather than aliased into the array.
  assign ld_idx_p0      = ld_addr[ADDR_W-1:OFF_W];
  assign ld_in_range_p0 = !idx_out_of_range(ld_idx_p0);
  assign unused_ld_off  = ^ld_addr[OFF_W-1:0];

  // Memory writes are unaffected by reset. Because a fetch is never accepted
  // in a load cycle, a fetch in the following cycle always reads the new word.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range_p0) begin
      mem[ld_idx_p0[MEM_AW-1:0]] <= ld_data;
    end
  end

  // ---- stage p1: response register ----------------------------------------
  // Data and fault change only on an accepting edge or on reset, so a held
  // response stays stable under backpressure. An accept takes priority over
  // emptying: a flush or consume in the same cycle simply makes room for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= EMPTY;
      data_p1  <= '0;
      fault_p1 <= '0;
    end else if (accept_p0) begin
      state_p1 <= FULL;
      fault_p1 <= fault_p0;
      data_p1  <= (fault_p0 != 2'b00) ? NOP_WORD : mem[req_idx_p0[MEM_AW-1:0]];
    end else if ((state_p1 == FULL) && (rsp_ready || flush)) begin
      state_p1 <= EMPTY;
    end
  end

  assign rsp_valid = (state_p1 == FULL);
  assign rsp_data  = data_p1;
  assign rsp_fault = fault_p1;

endmodule

// File: tb/tb_instr_rom_fetch.sv
module tb_instr_rom_fetch;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_fault;
  logic          flush;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_rom_fetch #(
    .DATA_W  (32),
    .DEPTH   (128),
    .ADDR_W  (AW),
    .NOP_WORD(32'h00000013)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    fault;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_req_ready", req_ready, 1);
    tick(); tick();
    rst = 1'b0;

    // Load collides with a fetch: load wins, fetch waits
    ld_en = 1'b1; ld_addr = 10'd4; ld_data = 32'h00348093;
    req_valid = 1'b1; req_addr = 10'd4; rsp_ready = 1'b1;
    #1 check("ld_blocks_req_ready", req_ready, 0);
    tick();
    check("ld_cycle_no_rsp", rsp_valid, 0);
    ld_en = 1'b0;
    #1 check("after_ld_req_ready", req_ready, 1);
    tick();
    check("wtr_rsp_valid", rsp_valid, 1);
    check("wtr_rsp_data",  rsp_data,  32'h00348093);
    check("wtr_rsp_fault", rsp_fault, 0);
    req_valid = 1'b0;
    tick();
    check("drain_rsp_valid", rsp_valid, 0);

    // More loads: offset bits ignored, out-of-range load dropped
    ld_en = 1'b1; ld_addr = 10'd13; ld_data = 32'h00a00113;
    tick();
    ld_addr = 10'd512; ld_data = 32'hffffffff;
    tick();
    ld_en = 1'b0;

    // Table-driven back-to-back fetches with rsp_ready held high
    vecs[0] = '{10'd4,   32'h00348093, 2'b00};
    vecs[1] = '{10'd8,   32'h00000013, 2'b00};
    vecs[2] = '{10'd12,  32'h00a00113, 2'b00};
    vecs[3] = '{10'd16,  32'h00000013, 2'b00};
    vecs[4] = '{10'd6,   32'h00000013, 2'b01};
    vecs[5] = '{10'd512, 32'h00000013, 2'b10};
    vecs[6] = '{10'd514, 32'h00000013, 2'b11};
    vecs[7] = '{10'd508, 32'h00000013, 2'b00};
    vecs[8] = '{10'd0,   32'h00000013, 2'b00};
    vecs[9] = '{10'd13,  32'h00000013, 2'b01};
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_addr = vecs[i].addr;
      #1 check($sformatf("vec%0d_req_ready", i), req_ready, 1);
      tick();
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("vec%0d_rsp_data", i),  rsp_data,  vecs[i].data);
      check($sformatf("vec%0d_rsp_fault", i), rsp_fault, vecs[i].fault);
    end
    req_valid = 1'b0;
    tick();
    check("tbl_drain_rsp_valid", rsp_valid, 0);

    // Backpressure for 3 cycles, then flush with a new request
    req_valid = 1'b1; req_addr = 10'd12;
    tick();
    req_addr = 10'd8; rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp%0d_req_ready", c), req_ready, 0);
      tick();
      check($sformatf("bp%0d_rsp_valid", c), rsp_valid, 1);
      check($sformatf("bp%0d_rsp_data", c),  rsp_data,  32'h00a00113);
      check($sformatf("bp%0d_rsp_fault", c), rsp_fault, 0);
    end
    flush = 1'b1;
    #1 check("flush_req_ready", req_ready, 1);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_rsp_valid", rsp_valid, 1);
    check("flush_rsp_data",  rsp_data,  32'h00000013);
    check("flush_rsp_fault", rsp_fault, 0);

    // Flush without a new request empties the response register
    tick();
    check("flush_only_hold", rsp_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_only_empty", rsp_valid, 0);
    check("flush_only_data_kept", rsp_data, 32'h00000013);

    // Reset asserted while a response is held
    req_valid = 1'b1; req_addr = 10'd16; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("pre_rst_rsp_valid", rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_rsp_data",  rsp_data,  0);
    tick();
    rst = 1'b0;
    req_valid = 1'b1; req_addr = 10'd4; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("post_rst_rsp_valid", rsp_valid, 1);
    check("post_rst_rsp_data",  rsp_data,  32'h00348093);
    check("post_rst_rsp_fault", rsp_fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_rom_fetch.md
# instr_rom_fetch

Parametrised, synchronous instruction memory for the CPU fetch stage, replacing the fixed 128-word, combinational-read instruction ROM. It accepts byte-addressed fetch requests over a valid/ready handshake and returns one registered instruction word per accepted request. It also provides a word-write load port for programming contents at run time, a flush input for branch redirects, and alignment/range fault reporting.

## Interface
Parameters:
- DATA_W, 32, instruction word width in bits; multiple of 8, power-of-two bytes.
- DEPTH, 128, number of words stored.
- ADDR_W, 9, byte-address width; DEPTH ≤ 2^(ADDR_W − log2(DATA_W/8)).
- NOP_WORD, 32'h00000013, word returned on fault and initial content of every location (`addi x0 x0 0`).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_W  fetch byte address.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- rsp_valid  out  1  rsp_data/rsp_fault hold a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_data  out  DATA_W  fetched instruction word.
- rsp_fault  out  2  bit0 misaligned, bit1 out of range.
- flush  in  1  discard any held response.
- ld_en  in  1  write ld_data into memory this cycle.
- ld_addr  in  ADDR_W  byte address of word to load; low alignment bits ignored.
- ld_data  in  DATA_W  word to store.

## Operation
- Word index = req_addr >> log2(DATA_W/8); alignment bits = low log2(DATA_W/8) bits of req_addr.
- Accept = req_valid && req_ready. req_ready = !ld_en && (!rsp_valid || rsp_ready || flush).
- On accept: next cycle, rsp_valid=1, rsp_fault set per request, rsp_data = mem[index] if rsp_fault==0, else NOP_WORD.
- Misaligned: alignment bits ≠ 0 → bit0. Range: index ≥ DEPTH → bit1. Both bits may be set; any set bit forces rsp_data=NOP_WORD.
- Response register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL with new data on accept, which requires rsp_ready or flush.
  - FULL→EMPTY on (rsp_ready || flush) with no accept.
  - FULL holds data and fault unchanged while rsp_ready=0, flush=0.
- flush with simultaneous accept: old response discarded, new request's response appears next cycle.
- Load port:
  - ld_en writes mem[ld_addr index] at clock edge; writes with out-of-range index are dropped silently.
  - Load has priority over fetch: req_ready=0 while ld_en=1.
- Write-then-read: a fetch accepted the cycle after a load to the same word returns the new data.
- Memory contents are not affected by rst; all words power up as NOP_WORD.

## Timing
- Read latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 fetch per cycle when rsp_ready is held high.
- Reset values: rsp_valid=0, rsp_data=0, rsp_fault=0. req_ready follows the formula above, so it is 1 during reset when ld_en=0.
- Reset asserted mid-operation: rsp_valid clears immediately (asynchronously). Any request in flight is lost; memory contents are retained.
- rsp_data and rsp_fault change only on an accepting edge or on reset.

## Test plan
- After reset, load 0x00348093 at byte address 4, then fetch address 4 with rsp_ready=1 → one cycle later rsp_valid=1, rsp_data=0x00348093, rsp_fault=0.
- Back-to-back fetches of 4, 8, 12, 16 with rsp_ready=1 → four consecutive responses, one per cycle, in order. Unloaded words return 0x00000013.
- Fetch address 6 → rsp_fault=2'b01, rsp_data=0x00000013. Fetch address 512 (ADDR_W=10) → rsp_fault=2'b10.
- Backpressure: rsp_valid=1 and rsp_ready=0 for 3 cycles → req_ready=0, response held stable. Assert flush with req_valid at address 8 → next cycle response is for address 8, old response never consumed.
- ld_en=1 together with req_valid → req_ready=0 that cycle. Next cycle, fetch of the loaded address is accepted and returns the new word.
- Assert rst while rsp_valid=1 → rsp_valid drops before the next edge. After release, re-fetching address 4 returns the previously loaded 0x00348093.
